// File: rtl/mnist_layer_sequencer_pkg.sv
// Shared definitions for the MNIST layer sequencer: default layer geometry
// and the sequencer FSM state encoding.
package mnist_layer_sequencer_pkg;

  localparam int unsigned N_IN_DEFAULT    = 784;
  localparam int unsigned N_OUT_DEFAULT   = 10;
  localparam int unsigned MEM_LAT_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mnist_layer_sequencer_valid_delay.sv
// Issue-flag delay line: matches the xmem/wmem read latency so that the MAC
// enable lines up with the data the addresses fetched. Flushable on abort.
module mnist_layer_sequencer_valid_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] stage_q;

  // Shift the issue flag one stage per cycle; a flush empties every stage at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (flush_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= valid_i;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign valid_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mnist_layer_sequencer.sv
// Sequences one fully-connected layer over a single shared MAC: walks every
// neuron across every input, drives xmem/wmem addresses, strobes the MAC and
// writes each finished accumulator into the result bank.
module mnist_layer_sequencer
  import mnist_layer_sequencer_pkg::*;
#(
  parameter int unsigned N_IN     = N_IN_DEFAULT,
  parameter int unsigned N_OUT    = N_OUT_DEFAULT,
  parameter int unsigned X_ADDR_W = 10,
  parameter int unsigned W_ADDR_W = 13,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned MEM_LAT  = MEM_LAT_DEFAULT,
  parameter int unsigned ACC_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [X_ADDR_W-1:0] x_addr_o,
  output logic [W_ADDR_W-1:0] w_addr_o,
  output logic                mac_clr_o,
  output logic                mac_en_o,
  input  logic [ACC_W-1:0]    acc_in_i,
  output logic                res_we_o,
  output logic [IDX_W-1:0]    res_idx_o,
  output logic [ACC_W-1:0]    res_data_o
);

  localparam int unsigned DRAIN_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [X_ADDR_W-1:0] X_LAST     = X_ADDR_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_OUT - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(MEM_LAT - 1);

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 mac_clr_q;
  logic                 res_we_q;
  logic [X_ADDR_W-1:0]  x_addr_q;
  logic [W_ADDR_W-1:0]  w_addr_q;
  logic [IDX_W-1:0]     neuron_q;
  logic [DRAIN_W-1:0]   drain_q;

  logic                 flush;
  logic                 issue;

  // Abort only matters once a run is in flight; in IDLE it also suppresses start.
  assign flush = abort_i && (state_q != ST_IDLE);
  assign issue = (state_q == ST_FEED);

  // Main sequencer FSM; every strobe and address is registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      res_we_q  <= 1'b0;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
      neuron_q  <= '0;
      drain_q   <= '0;
    end else if (flush) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      res_we_q  <= 1'b0;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
      neuron_q  <= '0;
      drain_q   <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      res_we_q  <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_q   <= ST_CLEAR;
            busy_q    <= 1'b1;
            mac_clr_q <= 1'b1;
            neuron_q  <= '0;
            x_addr_q  <= '0;
            w_addr_q  <= '0;
          end
        end
        ST_CLEAR: begin
          state_q  <= ST_FEED;
          x_addr_q <= '0;
        end
        ST_FEED: begin
          if (x_addr_q == X_LAST) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end else begin
            x_addr_q <= x_addr_q + X_ADDR_W'(1);
            w_addr_q <= w_addr_q + W_ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q  <= ST_WRITE;
            res_we_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        ST_WRITE: begin
          if (neuron_q == IDX_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= ST_CLEAR;
            mac_clr_q <= 1'b1;
            neuron_q  <= neuron_q + IDX_W'(1);
            x_addr_q  <= '0;
            w_addr_q  <= w_addr_q + W_ADDR_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mnist_layer_sequencer_valid_delay #(
    .DEPTH (MEM_LAT)
  ) u_valid_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .valid_i (issue),
    .valid_o (mac_en_o)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mac_clr_o  = mac_clr_q;
  assign res_we_o   = res_we_q;
  assign x_addr_o   = x_addr_q;
  assign w_addr_o   = w_addr_q;
  assign res_idx_o  = neuron_q;
  assign res_data_o = res_we_q ? acc_in_i : '0;

endmodule
